// File: rtl/tt_um_mr_latch_sar.sv
// tt_um_mr_latch_sar: 8-bit successive-approximation controller with synchronized comparator input.
// Revision 1.0
`default_nettype none

module tt_um_mr_latch_sar #(
   parameter int NBITS       = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ena,
   input  logic [7:0]       ui_in,
   input  logic [7:0]       uio_in,
   output logic [NBITS-1:0] uo_out,
   output logic [7:0]       uio_out,
   output logic [7:0]       uio_oe
);

   localparam int CW = 5;
   localparam int IW = $clog2(NBITS);
   localparam logic [CW-1:0] SYNC_LOAD = CW'(SYNC_STAGES);

   typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

   state_t                 state;
   logic [SYNC_STAGES-1:0] sync;
   logic                   start_q;
   logic [NBITS-1:0]       trial;
   logic [NBITS-1:0]       result;
   logic [IW-1:0]          bit_idx;
   logic [CW-1:0]          counter;
   logic [3:0]             n_set;
   logic                   valid;
   logic                   done_r;

   logic          comp_sync;
   logic          start_evt;
   logic          cont;
   logic          abort;
   logic          busy;
   logic [IW-1:0] idx_m1;
   logic          unused_pins;

   assign comp_sync   = sync[SYNC_STAGES-1];
   assign start_evt   = ui_in[1] & ~start_q;
   assign cont        = ui_in[2];
   assign abort       = ui_in[3];
   assign busy        = (state != IDLE);
   assign idx_m1      = bit_idx - 1'b1;
   assign unused_pins = &{1'b0, ui_in[7:4], uio_in[3:0]};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         sync    <= '0;
         start_q <= 1'b0;
         trial   <= '0;
         result  <= '0;
         bit_idx <= '0;
         counter <= '0;
         n_set   <= '0;
         valid   <= 1'b0;
         done_r  <= 1'b0;
      end else if (ena) begin
         sync    <= {sync[SYNC_STAGES-2:0], ui_in[0]};
         start_q <= ui_in[1];
         done_r  <= 1'b0;
         case (state)
            IDLE: begin
               if (!abort && (start_evt || cont)) begin
                  state   <= SETTLE;
                  trial   <= NBITS'(1) << (NBITS - 1);
                  bit_idx <= IW'(NBITS - 1);
                  n_set   <= uio_in[7:4];
                  counter <= {1'b0, uio_in[7:4]} + SYNC_LOAD;
               end
            end
            SETTLE: begin
               if (abort) begin
                  state <= IDLE;
               end else begin
                  counter <= (counter == '0) ? '0 : counter - 1'b1;
                  if (counter <= CW'(1)) state <= SAMPLE;
               end
            end
            SAMPLE: begin
               if (abort) begin
                  state <= IDLE;
               end else begin
                  trial[bit_idx] <= comp_sync;
                  if (bit_idx != '0) begin
                     trial[idx_m1] <= 1'b1;
                     bit_idx       <= idx_m1;
                     counter       <= {1'b0, n_set} + SYNC_LOAD;
                     state         <= SETTLE;
                  end else begin
                     // done is raised on entry so the pulse lines up with the DONE cycle
                     state  <= DONE;
                     done_r <= 1'b1;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
               if (!abort) begin
                  result <= trial;
                  valid  <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign uo_out  = busy ? trial : result;
   assign uio_out = {4'b0000, comp_sync, valid, done_r & ~abort, busy};
   assign uio_oe  = 8'h0F;

endmodule

`default_nettype wire

// File: tb/tb_tt_um_mr_latch_sar.sv
// tb_tt_um_mr_latch_sar: directed scoreboard bench for the SAR controller.
`default_nettype none

module tb_tt_um_mr_latch_sar;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ena = 1'b1;
   logic       start = 1'b0;
   logic       cont = 1'b0;
   logic       abort = 1'b0;
   logic [7:0] vin = 8'h00;
   logic [7:0] uio_in = 8'h00;
   logic [7:0] ui_in;
   logic [7:0] uo_out;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;
   logic       comp;

   logic [7:0] sb[$];
   int         checks = 0;
   int         errors = 0;

   always #5 clk = ~clk;

   // Ideal comparator: analog input against the DAC code currently driven
   assign comp  = (vin >= uo_out);
   assign ui_in = {4'b0000, abort, cont, start, comp};

   tt_um_mr_latch_sar #(.NBITS(8), .SYNC_STAGES(2)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ena     (ena),
      .ui_in   (ui_in),
      .uio_in  (uio_in),
      .uo_out  (uo_out),
      .uio_out (uio_out),
      .uio_oe  (uio_oe)
   );

   wire busy  = uio_out[0];
   wire done  = uio_out[1];
   wire valid = uio_out[2];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One start-launched conversion; optional start re-pulse and ena gap while busy
   task automatic convert(input logic [7:0] v, input logic [3:0] n, input int exp_busy,
                          input bit repulse, input int gap_at);
      int count;
      int guard;
      bit got;
      logic [7:0] exp;
      vin = v;
      uio_in = {n, 4'h0};
      sb.push_back(v);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      count = 0;
      guard = 0;
      got = 1'b0;
      while (!got && guard < 400) begin
         guard++;
         if (busy) count++;
         if (done) begin
            got = 1'b1;
            check("busy_len", count, exp_busy);
            exp = sb.pop_front();
            check("result_at_done", uo_out, exp);
         end
         start = repulse && (count == 20);
         ena = !(gap_at > 0 && count >= gap_at && count < gap_at + 10);
         @(negedge clk);
      end
      start = 1'b0;
      ena = 1'b1;
      check("done_seen", got, 1);
      check("idle_after", busy, 0);
      check("valid_after", valid, 1);
      check("result_after", uo_out, v);
   endtask

   initial begin
      int  t;
      int  last;
      int  ndone;
      bit  saw_done;
      logic [7:0] exp;

      // Reset held across two edges
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_uo_out", uo_out, 8'h00);
      check("rst_uio_out", uio_out, 8'h00);
      check("rst_uio_oe", uio_oe, 8'h0F);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("idle_busy", busy, 0);

      convert(8'hA5, 4'd0, 25, 1'b0, 0);
      convert(8'hFF, 4'd0, 25, 1'b0, 0);
      convert(8'h00, 4'd0, 25, 1'b0, 0);
      convert(8'h80, 4'd0, 25, 1'b0, 0);
      convert(8'h3C, 4'd15, 145, 1'b1, 0);
      convert(8'hA5, 4'd0, 25, 1'b0, 0);

      // Abort during bit 4 keeps the previous A5 result
      vin = 8'h33;
      uio_in = 8'h00;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      saw_done = 1'b0;
      t = 1;
      while (t < 10) begin
         if (done) saw_done = 1'b1;
         @(negedge clk);
         t++;
      end
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      if (done) saw_done = 1'b1;
      check("abort_busy", busy, 0);
      check("abort_uo_out", uo_out, 8'hA5);
      check("abort_valid", valid, 1);
      repeat (30) begin
         @(negedge clk);
         if (done || busy) saw_done = 1'b1;
      end
      check("abort_no_done", saw_done, 0);

      // Abort held in IDLE blocks the start launch
      abort = 1'b1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("abort_idle_block", busy, 0);
      @(negedge clk);
      abort = 1'b0;
      @(negedge clk);
      check("abort_idle_stay", busy, 0);

      // Reset mid-conversion abandons it
      vin = 8'h77;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check("midrst_uo_out", uo_out, 8'h00);
      check("midrst_valid", valid, 0);
      check("midrst_busy", busy, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Continuous mode: four conversions, cont dropped during the fourth
      vin = 8'h5A;
      uio_in = 8'h00;
      repeat (4) sb.push_back(8'h5A);
      cont = 1'b1;
      @(negedge clk);
      t = 0;
      last = 0;
      ndone = 0;
      while (ndone < 4 && t < 300) begin
         t++;
         if (done) begin
            ndone++;
            if (ndone > 1) check("cont_period", t - last, 26);
            last = t;
            exp = sb.pop_front();
            check("cont_result", uo_out, exp);
         end
         if (ndone == 3 && t == last + 5) cont = 1'b0;
         @(negedge clk);
      end
      cont = 1'b0;
      check("cont_count", ndone, 4);
      repeat (3) @(negedge clk);
      check("cont_stopped", busy, 0);

      // ena gap of 10 cycles stretches the conversion by 10
      convert(8'hA5, 4'd0, 35, 1'b0, 5);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/tt_um_mr_latch_sar.md
TT_UM_MR_LATCH_SAR -- requirements
Module: tt_um_mr_latch_sar

Interface
REQ-001 Parameter: NBITS, 8, conversion width; fixed at 8 for the TT pinout.
REQ-002 Parameter: SYNC_STAGES, 2, comparator synchronizer depth; allowed values 2..3.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset.
REQ-005 ena  input  1  design enable; 0 freezes all state, outputs hold.
REQ-006 ui_in  input  8  [0] comp (1 = analog input >= DAC), [1] start, [2] cont, [3] abort, [7:4] unused.
REQ-007 uio_in  input  8  [7:4] settle count N_SET (0..15), latched at conversion start; [3:0] ignored.
REQ-008 uo_out  output  8  DAC code: trial code while busy, else result register.
REQ-009 uio_out  output  8  [0] busy, [1] done (1-cycle pulse), [2] valid (sticky), [3] comp_sync (debug), [7:4] = 0.
REQ-010 uio_oe  output  8  constant 8'h0F.

Function
REQ-011 The comparator input shall pass through a SYNC_STAGES-flop synchronizer to form comp_sync before any use.
REQ-012 Start detection: start_q registers ui_in[1]; a start event is ui_in[1]=1 with start_q=0.
REQ-013 FSM states: IDLE, SETTLE, SAMPLE, DONE.
REQ-014 IDLE -> SETTLE on a start event, or when cont=1, with trial=8'h80, bit_idx=7, counter=N_SET+SYNC_STAGES, N_SET latched from uio_in[7:4].
REQ-015 SETTLE: counter decrements each cycle; on the cycle counter=1 (or already 0) -> SAMPLE; SETTLE lasts N_SET+SYNC_STAGES cycles.
REQ-016 SAMPLE (1 cycle): trial[bit_idx] <= comp_sync.
REQ-017 SAMPLE with bit_idx>0: set trial[bit_idx-1]=1, decrement bit_idx, reload counter, go to SETTLE.
REQ-018 SAMPLE with bit_idx=0: go to DONE.
REQ-019 DONE (1 cycle): result <= trial, done=1, valid <= 1, then go to IDLE.
REQ-020 Conversion length: 8*(N_SET+SYNC_STAGES+1)+1 cycles from the IDLE exit edge through DONE; 25 cycles at N_SET=0, SYNC_STAGES=2.
REQ-021 busy=1 in SETTLE, SAMPLE and DONE; busy=0 in IDLE.
REQ-022 A start event while busy shall be ignored; start_q tracks ui_in[1] regardless of state.
REQ-023 abort=1 in any busy state: next state IDLE; result and valid unchanged; no done pulse; abort takes priority over DONE completion.
REQ-024 abort=1 in IDLE blocks both the start and the cont launch.
REQ-025 cont=1: each DONE -> IDLE is followed by an immediate relaunch; the period is 26 cycles at N_SET=0.
REQ-026 cont deasserted mid-conversion: the current conversion completes, then the FSM stays in IDLE.
REQ-027 ena=0 shall freeze all registers, including the synchronizer and start_q; on return to ena=1, operation resumes where it stopped.
REQ-028 The comparator sense is unsigned: comp_sync=1 keeps the bit. Result 8'hFF is reachable when comp is always 1; 8'h00 when comp is always 0.

Reset
REQ-029 rst_n=0 at a clock edge: state=IDLE, trial=0, result=0, valid=0, done=0, start_q=0, synchronizer=0, N_SET latch=0.
REQ-030 During and after reset: uo_out=8'h00, uio_out=8'h00, uio_oe=8'h0F.
REQ-031 Reset applied mid-conversion shall abandon the conversion; there is no done pulse and the result stays 0.
REQ-032 Reset takes priority over ena and abort.

Verification
REQ-033 Reset check: after rst_n low for 2 cycles -> uo_out=00, uio_out=00, uio_oe=0F.
REQ-034 Bench comparator model comp=(VIN>=uo_out), VIN=8'hA5, N_SET=0, single start pulse -> busy for 25 cycles, done pulse on the last one, uo_out=A5, valid=1.
REQ-035 Extremes: VIN=8'hFF -> result FF; VIN=8'h00 -> result 00; VIN=8'h80 -> result 80.
REQ-036 Timing: N_SET=15, VIN=8'h3C -> result 3C after 145 busy cycles; a start re-pulsed while busy is ignored.
REQ-037 Abort: after a prior result A5, abort asserted during bit 4 -> busy=0 next cycle, uo_out=A5, no done pulse. Separately, rst_n low mid-conversion -> uo_out=00, valid=0.
REQ-038 Continuous: cont=1, VIN=8'h5A, N_SET=0 -> done pulses every 26 cycles, each result 5A. Clearing cont stops the FSM after the current DONE. ena=0 for 10 cycles mid-conversion extends busy by exactly 10 cycles.
